// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the two-requester VRAM CPU-port arbiter.
package vram_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    // Longest uninterrupted LOCK1 residency before r0 is forced back in.
    localparam int LOCK_MAX   = 64;
    localparam int LOCK_CNT_W = 6;

    localparam logic ID_R0 = 1'b0;
    localparam logic ID_R1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, on contention the
// requester that did not win last time gets the grant. last=1 means r1 won last.
module rr_pick2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    // Grants are one-hot or zero by construction.
    always_comb begin
        gnt0 = valid0 & (~valid1 | last);
        gnt1 = valid1 & (~valid0 | ~last);
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the MemoryUnit (r0) and DMA/blitter (r1) onto the single VRAM
// CPU port. One request accepted per cycle, registered onto vram_*; read data
// returns two cycles after acceptance, steered by an inline {valid,id} tag pipe.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              nreset,

    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [WIDTH-1:0]  r0_d,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [WIDTH-1:0]  r0_q,

    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [WIDTH-1:0]  r1_d,
    input  logic              r1_lock,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [WIDTH-1:0]  r1_q,

    output logic [ADDR_W-1:0] vram_addr,
    output logic [WIDTH-1:0]  vram_d,
    output logic              vram_we,
    input  logic [WIDTH-1:0]  vram_q
);

    localparam int TAG_STAGES = 2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  d;
    } vram_req_t;

    arb_state_e            state, state_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  last_grant;
    logic                  rr_gnt0, rr_gnt1;
    logic                  r0_acc, r1_acc, acc;
    logic                  rd_acc;
    vram_req_t             sel_req;
    logic [TAG_STAGES:1]   vld_pipe;
    logic [TAG_STAGES:1]   id_pipe;

    rr_pick2 u_pick (
        .valid0 (r0_valid),
        .valid1 (r1_valid),
        .last   (last_grant),
        .gnt0   (rr_gnt0),
        .gnt1   (rr_gnt1)
    );

    // Grant generation and lock FSM next state; nothing is granted in reset.
    always_comb begin
        state_nxt = state;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        unique case (state)
            ARB: begin
                r0_ready = rr_gnt0;
                r1_ready = rr_gnt1;
                if (rr_gnt1 && r1_lock)
                    state_nxt = LOCK1;
            end
            LOCK1: begin
                r1_ready = r1_valid;
                // lock_cnt counts LOCK1 cycles already spent, so this releases
                // at the end of the 64th one.
                if (!r1_valid || !r1_lock || lock_cnt == LOCK_CNT_W'(LOCK_MAX - 1))
                    state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
        if (!nreset) begin
            r0_ready = 1'b0;
            r1_ready = 1'b0;
        end
    end

    // Accepted request selection.
    always_comb begin
        r0_acc  = r0_valid & r0_ready;
        r1_acc  = r1_valid & r1_ready;
        acc     = r0_acc | r1_acc;
        sel_req = r1_acc ? '{we: r1_we, addr: r1_addr, d: r1_d}
                         : '{we: r0_we, addr: r0_addr, d: r0_d};
        rd_acc  = acc & ~sel_req.we;
    end

    // FSM state, lock residency counter and round-robin history.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= ARB;
            lock_cnt   <= '0;
            last_grant <= ID_R1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= (state == LOCK1 && state_nxt == LOCK1) ? lock_cnt + 1'b1 : '0;
            if (acc)
                last_grant <= r1_acc ? ID_R1 : ID_R0;
        end
    end

    // VRAM port registers: address/data hold when idle, write strobe is one-shot.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vram_addr <= '0;
            vram_d    <= '0;
            vram_we   <= 1'b0;
        end else begin
            vram_we <= acc & sel_req.we;
            if (acc) begin
                vram_addr <= sel_req.addr;
                vram_d    <= sel_req.d;
            end
        end
    end

    // Read tag pipe: stage 1 covers the VRAM address cycle, stage 2 the data cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[TAG_STAGES-1:1], rd_acc};
            id_pipe  <= {id_pipe[TAG_STAGES-1:1], r1_acc ? ID_R1 : ID_R0};
        end
    end

    // Response steering; data is zeroed whenever the requester has no response.
    always_comb begin
        r0_rvalid = vld_pipe[TAG_STAGES] & (id_pipe[TAG_STAGES] == ID_R0);
        r1_rvalid = vld_pipe[TAG_STAGES] & (id_pipe[TAG_STAGES] == ID_R1);
        r0_q      = r0_rvalid ? vram_q : '0;
        r1_q      = r1_rvalid ? vram_q : '0;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a one-cycle-latency VRAM behind it.
module tb_vram_arbiter;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              nreset;
    logic              r0_valid, r0_we, r0_ready, r0_rvalid;
    logic [ADDR_W-1:0] r0_addr;
    logic [WIDTH-1:0]  r0_d, r0_q;
    logic              r1_valid, r1_we, r1_lock, r1_ready, r1_rvalid;
    logic [ADDR_W-1:0] r1_addr;
    logic [WIDTH-1:0]  r1_d, r1_q;
    logic [ADDR_W-1:0] vram_addr;
    logic [WIDTH-1:0]  vram_d, vram_q;
    logic              vram_we;

    logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];
    int                n_tests = 0;
    int                n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .nreset(nreset),
        .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_d(r0_d),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_q(r0_q),
        .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_d(r1_d),
        .r1_lock(r1_lock), .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_q(r1_q),
        .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q)
    );

    // VRAM model: registered read, read-before-write on the same port.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_d;
        vram_q <= mem[vram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] exp_q [0:2];
        int               a0, a1;
        exp_q[0] = 32'h1111_1111;
        exp_q[1] = 32'h2222_2222;
        exp_q[2] = 32'h3333_3333;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[14'h0010] = 32'hDEAD_BEEF;
        mem[14'h0001] = exp_q[0];
        mem[14'h0002] = exp_q[1];
        mem[14'h0003] = exp_q[2];

        nreset = 1'b0;
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_d = '0;
        r1_valid = 1'b1; r1_we = 1'b0; r1_addr = '0; r1_d = '0; r1_lock = 1'b0;

        // Reset state with both requesters pushing.
        @(negedge clk);
        chk("rst_r0_ready", r0_ready, 0);
        chk("rst_r1_ready", r1_ready, 0);
        chk("rst_vram_we", vram_we, 0);
        chk("rst_vram_addr", vram_addr, 0);
        chk("rst_vram_d", vram_d, 0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        cyc();
        nreset = 1'b1;
        cyc();

        // Single read by r0 from 0x0010.
        r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 14'h0010;
        @(negedge clk); chk("rd_ready", r0_ready, 1);
        cyc(); r0_valid = 1'b0;
        @(negedge clk);
        chk("rd_vram_addr", vram_addr, 14'h0010);
        chk("rd_vram_we", vram_we, 0);
        chk("rd_early_rvalid", r0_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("rd_rvalid", r0_rvalid, 1);
        chk("rd_q", r0_q, 32'hDEAD_BEEF);
        chk("rd_r1_rvalid", r1_rvalid, 0);
        chk("rd_r1_q", r1_q, 0);
        cyc();
        @(negedge clk);
        chk("rd_rvalid_once", r0_rvalid, 0);
        chk("rd_q_zero", r0_q, 0);

        // Write by r1: 0x00AB to 0x0200.
        cyc();
        r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 14'h0200; r1_d = 32'h0000_00AB;
        @(negedge clk); chk("wr_ready", r1_ready, 1);
        cyc(); r1_valid = 1'b0; r1_we = 1'b0;
        @(negedge clk);
        chk("wr_vram_we", vram_we, 1);
        chk("wr_vram_addr", vram_addr, 14'h0200);
        chk("wr_vram_d", vram_d, 32'h0000_00AB);
        cyc();
        @(negedge clk);
        chk("wr_we_once", vram_we, 0);
        chk("wr_addr_hold", vram_addr, 14'h0200);
        chk("wr_no_rvalid", {r0_rvalid, r1_rvalid}, 0);
        cyc();
        @(negedge clk);
        chk("wr_no_rvalid2", {r0_rvalid, r1_rvalid}, 0);
        chk("wr_mem", mem[14'h0200], 32'h0000_00AB);

        // Back-to-back reads 0x1, 0x2, 0x3 by r0.
        cyc();
        for (int i = 0; i < 6; i++) begin
            logic             rv;
            logic [WIDTH-1:0] eq;
            r0_valid = (i < 3);
            r0_addr  = ADDR_W'(i + 1);
            rv = (i >= 2) && (i < 5);
            eq = rv ? exp_q[i-2] : '0;
            @(negedge clk);
            chk("b2b_ready", r0_ready, (i < 3));
            chk("b2b_rvalid", r0_rvalid, rv);
            chk("b2b_q", r0_q, eq);
            cyc();
        end
        r0_valid = 1'b0;

        // Reset while an r0 read is in flight.
        r0_valid = 1'b1; r0_addr = 14'h0010;
        @(negedge clk); chk("mid_ready", r0_ready, 1);
        cyc();
        r0_valid = 1'b0; nreset = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_rst", r0_rvalid, 0);
        chk("mid_vram_addr", vram_addr, 0);
        cyc();
        @(negedge clk); chk("mid_rvalid_rst2", r0_rvalid, 0);
        cyc();
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_post_rvalid", {r0_rvalid, r1_rvalid}, 0);
            chk("mid_post_vram", {vram_we, vram_addr, vram_d}, 0);
            chk("mid_post_q", {r0_q, r1_q}, 0);
            cyc();
        end

        // Contention right after reset: r0 first, then strict alternation.
        r0_valid = 1'b1; r0_addr = 14'h0004;
        r1_valid = 1'b1; r1_addr = 14'h0005;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("cont_r0", r0_ready, (i % 2 == 0));
            chk("cont_r1", r1_ready, (i % 2 == 1));
            a0 += int'(r0_ready); a1 += int'(r1_ready);
            cyc();
        end
        chk("cont_r0_share", a0, 4);
        chk("cont_r1_share", a1, 4);

        // Lock: r1 acquires alone, then holds the port for 64 LOCK1 cycles.
        r0_valid = 1'b0; r1_lock = 1'b1;
        @(negedge clk); chk("lock_acq", r1_ready, 1);
        cyc();
        r0_valid = 1'b1;
        a0 = 0; a1 = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            a0 += int'(r0_ready); a1 += int'(r1_ready);
            cyc();
        end
        chk("lock_r0_blocked", a0, 0);
        chk("lock_r1_owned", a1, 64);
        @(negedge clk);
        chk("lock_timeout_r0", r0_ready, 1);
        chk("lock_timeout_r1", r1_ready, 0);
        cyc();

        // r1 re-acquires; dropping lock in LOCK1 cycle 10 lets r0 in at 11.
        @(negedge clk); chk("lock2_acq", r1_ready, 1);
        cyc();
        a0 = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) r1_lock = 1'b0;
            @(negedge clk);
            a0 += int'(r0_ready);
            cyc();
        end
        chk("lock2_r0_blocked", a0, 0);
        @(negedge clk); chk("lock_drop_r0", r0_ready, 1);
        cyc();
        r0_valid = 1'b0; r1_valid = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, VRAM data width; 8 and 9 shall also be supported (vram8, vramSPR).
REQ-002 SHALL have parameter ADDR_W, default 14, VRAM CPU-port address width.
REQ-003 SHALL have port clk  input  1  single clock (50 MHz system clock); no other clock.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports r0_valid/r1_valid  input  1  request present, requester 0 (MemoryUnit) / requester 1 (DMA/blitter).
REQ-006 SHALL have ports r0_we/r1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports r0_addr/r1_addr  input  ADDR_W  word address.
REQ-008 SHALL have ports r0_d/r1_d  input  WIDTH  write data.
REQ-009 SHALL have port r1_lock  input  1  requester 1 keeps the grant while asserted with r1_valid.
REQ-010 SHALL have ports r0_ready/r1_ready  output  1  request accepted this cycle.
REQ-011 SHALL have ports r0_rvalid/r1_rvalid  output  1  read data valid this cycle.
REQ-012 SHALL have ports r0_q/r1_q  output  WIDTH  read data.
REQ-013 SHALL have ports vram_addr  output  ADDR_W, vram_d  output  WIDTH, vram_we  output  1, all registered, driving the VRAM CPU port.
REQ-014 SHALL have port vram_q  input  WIDTH  VRAM CPU-port read data (registered in VRAM, one-cycle latency).

Function
REQ-015 SHALL accept at most one request per cycle; rN_ready SHALL be combinational from rN_valid and the arbitration state, and acceptance occurs when rN_valid & rN_ready.
REQ-016 SHALL register the accepted request's addr/d/we onto vram_* at the end of acceptance cycle N.
REQ-017 SHALL drive vram_we=0 in any cycle following a cycle with no acceptance.
REQ-018 SHALL hold vram_addr at its previous value in any cycle following a cycle with no acceptance.
REQ-019 SHALL present a read accepted in cycle N as rN_rvalid=1 with rN_q=vram_q in cycle N+2, exactly one cycle, to the originating requester only.
REQ-020 SHALL NOT produce any response for writes.
REQ-021 SHALL track in-flight reads with a 2-stage {valid, id} tag pipeline.
REQ-022 SHALL use round-robin arbitration when both requesters are valid: grant goes to the requester not granted last.
REQ-023 SHALL grant a single valid requester immediately.
REQ-024 SHALL use a 1-bit last_grant register, updated only on acceptance.
REQ-025 SHALL implement lock as a state machine with states ARB and LOCK1.
REQ-026 SHALL move ARB->LOCK1 on acceptance of r1 with r1_lock=1.
REQ-027 SHALL, in LOCK1, give r1_ready=r1_valid and hold r0_ready=0.
REQ-028 SHALL move LOCK1->ARB when r1_lock=0 or when r1_valid=0 for one cycle.
REQ-029 SHALL force LOCK1->ARB after 64 consecutive LOCK1 cycles (6-bit counter) and SHALL then grant r0 first if r0_valid.
REQ-030 SHALL, on a read and a write to the same address in consecutive cycles, return the VRAM's ordering (read-before-write per port) without forwarding.
REQ-031 SHALL drive rN_q=0 whenever rN_rvalid=0.

Reset
REQ-032 SHALL, while nreset=0, clear vram_addr, vram_d and vram_we to 0.
REQ-033 SHALL, while nreset=0, clear the tag pipeline and the lock counter, set the state to ARB, and set last_grant=1 so r0 wins first.
REQ-034 SHALL hold rN_ready=0 and rN_rvalid=0 throughout reset.
REQ-035 SHALL discard reads in flight when reset is asserted mid-operation; no rvalid shall appear after release.
REQ-036 SHALL release reset asynchronously on assertion; the caller synchronizes deassertion (Stabilizer).

Structure
REQ-037 SHALL define the package vram_arb_pkg holding: state enum {ARB, LOCK1}, LOCK_MAX=64, requester-id constants ID_R0=0 and ID_R1=1.
REQ-038 SHALL place the round-robin pick in one natural sub-module rr_pick2 (inputs: valid0, valid1, last; outputs: gnt0, gnt1).
REQ-039 SHALL keep the tag pipeline inline.

Verification
REQ-040 SHALL cover single read: r0 reads 0x0010, vram_q=0xDEADBEEF in cycle N+2 -> r0_rvalid=1 and r0_q=0xDEADBEEF in cycle N+2 only; r1_rvalid stays 0.
REQ-041 SHALL cover contention: r0 and r1 both valid continuously after reset -> grants alternate r0,r1,r0,r1; each accepted 50% of the time.
REQ-042 SHALL cover write: r1 writes 0x00AB to 0x0200 -> vram_we=1, vram_addr=0x0200, vram_d=0x00AB for exactly one cycle; no rvalid.
REQ-043 SHALL cover lock: r1_lock=1 and r1_valid held, r0_valid=1 -> r1 owns the port 64 cycles, r0 accepted in cycle 65; r1_lock dropped at cycle 10 -> r0 granted at cycle 11.
REQ-044 SHALL cover reset mid-read: r0 read accepted, nreset=0 in cycle N+1 -> no r0_rvalid; after release all outputs are 0 and the first contended grant goes to r0.
REQ-045 SHALL cover back-to-back reads: r0 reads 0x1, 0x2, 0x3 in consecutive cycles -> three consecutive rvalid cycles, data in order.
